// File: rtl/btn_debounce_multi.sv
// ============================================================================
// Module   : btn_debounce_multi
// Purpose  : N-channel push-button conditioner: 2-flop sync, tick-sampled
//            agreement filter, press/release pulses and hold auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce_multi #(
    parameter int N_BTN          = 5,
    parameter int SAMPLE_DIV     = 250000,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_PERIOD  = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             sample_tick
);

    localparam int PW       = $clog2(SAMPLE_DIV);
    localparam int AW       = $clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [PW-1:0] DIV_LAST    = PW'(SAMPLE_DIV - 1);
    localparam logic [AW-1:0] AGREE_DONE  = AW'(STABLE_SAMPLES);
    localparam logic [HW-1:0] DELAY_DONE  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] PERIOD_DONE = HW'(REPEAT_PERIOD);
    localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    logic [PW-1:0]    presc;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    assign sample_tick = (presc == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (sample_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          level;
        logic [AW-1:0] agree;
        logic          agree_hit;
        logic          rise;
        logic          fall;
        logic          press_q;
        logic          rel_q;
        logic          rep_q;
        rep_state_t    state;
        rep_state_t    state_nx;
        logic [HW-1:0] hold;
        logic [HW-1:0] hold_nx;
        logic [HW-1:0] hold_inc;
        logic          rep_nx;

        // The STABLE_SAMPLES-th consecutive disagreeing sample flips the level.
        assign agree_hit = sample_tick && (sync2[i] != level) && ((agree + 1'b1) == AGREE_DONE);
        assign rise      = agree_hit & ~level;
        assign fall      = agree_hit & level;
        assign hold_inc  = hold + 1'b1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level   <= 1'b0;
                agree   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= rise;
                rel_q   <= fall;
                if (sample_tick) begin
                    if ((sync2[i] == level) || agree_hit) begin
                        agree <= '0;
                    end else begin
                        agree <= agree + 1'b1;
                    end
                    if (agree_hit) begin
                        level <= ~level;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_IDLE;
                hold  <= '0;
                rep_q <= 1'b0;
            end else begin
                state <= state_nx;
                hold  <= hold_nx;
                rep_q <= rep_nx;
            end
        end

        // A release always wins over a coinciding repeat tick.
        always_comb begin
            state_nx = state;
            hold_nx  = hold;
            rep_nx   = 1'b0;
            if (fall) begin
                state_nx = ST_IDLE;
                hold_nx  = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise && REPEAT_EN) begin
                            state_nx = ST_DELAY;
                            hold_nx  = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (sample_tick) begin
                            if (hold_inc == DELAY_DONE) begin
                                rep_nx   = 1'b1;
                                hold_nx  = '0;
                                state_nx = ST_REPEAT;
                            end else begin
                                hold_nx = hold_inc;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (sample_tick) begin
                            if (hold_inc == PERIOD_DONE) begin
                                rep_nx  = 1'b1;
                                hold_nx = '0;
                            end else begin
                                hold_nx = hold_inc;
                            end
                        end
                    end
                    default: begin
                        state_nx = ST_IDLE;
                        hold_nx  = '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;
        assign btn_repeat[i]  = rep_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_multi.sv
// ============================================================================
// Module   : tb_btn_debounce_multi
// Purpose  : Scenario bench for btn_debounce_multi against a tick-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_debounce_multi;

    localparam int N   = 2;
    localparam int DIV = 4;
    localparam int STB = 3;
    localparam int RD  = 5;
    localparam int RP  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic         sample_tick;

    int total = 0;
    int bad   = 0;

    btn_debounce_multi #(
        .N_BTN(N), .SAMPLE_DIV(DIV), .STABLE_SAMPLES(STB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    // Reference model: counts samples and ticks-since-press directly.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0;
    logic [N-1:0] m_press = '0, m_release = '0, m_repeat = '0;
    int           m_cnt = 0;
    int           m_agree [N];
    int           m_held  [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_s1 = '0; m_s2 = '0; m_level = '0;
            m_press = '0; m_release = '0; m_repeat = '0;
            for (int c = 0; c < N; c++) begin m_agree[c] = 0; m_held[c] = -1; end
        end else begin
            bit tk;
            tk = (m_cnt == DIV - 1);
            m_press = '0; m_release = '0; m_repeat = '0;
            for (int c = 0; c < N; c++) begin
                if (tk) begin
                    bit changed;
                    changed = 1'b0;
                    if (m_s2[c] == m_level[c]) begin
                        m_agree[c] = 0;
                    end else begin
                        m_agree[c]++;
                        if (m_agree[c] == STB) begin
                            m_agree[c] = 0;
                            m_level[c] = ~m_level[c];
                            changed = 1'b1;
                            if (m_level[c]) begin m_press[c] = 1'b1; m_held[c] = 0; end
                            else begin m_release[c] = 1'b1; m_held[c] = -1; end
                        end
                    end
                    if (!changed && m_held[c] >= 0) begin
                        m_held[c]++;
                        if (RD > 0 && m_held[c] >= RD && ((m_held[c] - RD) % RP) == 0)
                            m_repeat[c] = 1'b1;
                    end
                end
            end
            m_s2  = m_s1;
            m_s1  = btn_in;
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    wire [4*N:0] exp_vec = {m_level, m_press, m_release, m_repeat, (m_cnt == DIV - 1)};
    wire [4*N:0] dut_vec = {btn_level, btn_press, btn_release, btn_repeat, sample_tick};

    task automatic test_reset();
        int np = 0, nt = 0, last = -1;
        btn_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL reset_state: got %b want 0", dut_vec); end
        rst = 1'b0;
        btn_in = 2'b11;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL reset_pre cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
        end
        total++;
        if (btn_level !== 2'b11) begin bad++; $display("FAIL reset_held_level: got %b want 11", btn_level); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL reset_async: got %b want 0", dut_vec); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL reset_post cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
            if (btn_press == 2'b11) np++;
            if (sample_tick) begin
                if (last >= 0) begin
                    total++;
                    if (i - last != DIV) begin bad++; $display("FAIL tick_spacing: got %0d want %0d", i - last, DIV); end
                end
                last = i;
                nt++;
            end
        end
        total++;
        if (np != 1) begin bad++; $display("FAIL reset_repress: got %0d want 1", np); end
        total++;
        if (nt != 6) begin bad++; $display("FAIL tick_count: got %0d want 6", nt); end
        btn_in = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL reset_rel cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
        end
    endtask

    task automatic test_clean_press();
        int np = 0, n1 = 0;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        btn_in[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL clean cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
            if (btn_press[0]) np++;
            if (btn_level[1] || btn_press[1] || btn_release[1] || btn_repeat[1]) n1++;
        end
        total++;
        if (np != 1) begin bad++; $display("FAIL clean_press_count: got %0d want 1", np); end
        total++;
        if (n1 != 0) begin bad++; $display("FAIL clean_ch1_quiet: got %0d want 0", n1); end
        btn_in[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL clean_rel cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int np = 0, nr = 0;
        pat = 6'b111011;  // applied LSB first: 1,1,0,1,1,1
        for (int i = 0; i < 8 && m_cnt != 0; i++) @(negedge clk);
        for (int w = 0; w < 10; w++) begin
            btn_in[0] = (w < 6) ? pat[w] : 1'b1;
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                total++;
                if (dut_vec !== exp_vec) begin bad++; $display("FAIL bounce w%0d: got %b want %b", w, dut_vec, exp_vec); end
                if (btn_press[0]) np++;
                if (btn_release[0]) nr++;
            end
        end
        total++;
        if (np != 1) begin bad++; $display("FAIL bounce_press: got %0d want 1", np); end
        total++;
        if (nr != 0) begin bad++; $display("FAIL bounce_release: got %0d want 0", nr); end
        btn_in[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL bounce_rel cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
        end
    endtask

    task automatic test_repeat();
        int pc = -1, rc = -1, nrep = 0, nlate = 0;
        btn_in[1] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL repeat cyc%0d: got %b want %b", c, dut_vec, exp_vec); end
            if (btn_press[1] && pc < 0) pc = c;
            if (btn_repeat[1] && pc >= 0 && c - pc < 20 * DIV) begin
                nrep++;
                total++;
                if (c - pc < RD * DIV || ((c - pc - RD * DIV) % (RP * DIV)) != 0) begin
                    bad++; $display("FAIL repeat_phase: got %0d want %0d+k*%0d", c - pc, RD * DIV, RP * DIV);
                end
            end
            if (btn_release[1] && rc < 0) rc = c;
            if (rc >= 0 && c > rc && btn_repeat[1]) nlate++;
            if (pc >= 0 && c == pc + 20 * DIV) btn_in[1] = 1'b0;
            if (rc >= 0 && c > rc + 40) break;
        end
        total++;
        if (pc < 0 || rc < 0) begin bad++; $display("FAIL repeat_timeout: got press=%0d release=%0d want both >=0", pc, rc); end
        total++;
        if (nrep != 8) begin bad++; $display("FAIL repeat_count: got %0d want 8", nrep); end
        total++;
        if (nlate != 0) begin bad++; $display("FAIL repeat_after_release: got %0d want 0", nlate); end
        btn_in[1] = 1'b0;
    endtask

    task automatic test_simultaneous();
        int pc = -1, rc = -1, np = 0, nr = 0, nrep = 0, nmis = 0;
        btn_in = 2'b11;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL simul cyc%0d: got %b want %b", c, dut_vec, exp_vec); end
            if (btn_press == 2'b11) begin np++; if (pc < 0) pc = c; end
            if (btn_release == 2'b11) begin nr++; if (rc < 0) rc = c; end
            if (btn_repeat == 2'b11) nrep++;
            if (btn_press == 2'b01 || btn_press == 2'b10 || btn_release == 2'b01 ||
                btn_release == 2'b10 || btn_repeat == 2'b01 || btn_repeat == 2'b10) nmis++;
            if (pc >= 0 && c == pc + 10 * DIV) btn_in = 2'b00;
            if (rc >= 0 && c > rc + 30) break;
        end
        total++;
        if (np != 1) begin bad++; $display("FAIL simul_press: got %0d want 1", np); end
        total++;
        if (nr != 1) begin bad++; $display("FAIL simul_release: got %0d want 1", nr); end
        total++;
        if (nrep < 3) begin bad++; $display("FAIL simul_repeat: got %0d want >=3", nrep); end
        total++;
        if (nmis != 0) begin bad++; $display("FAIL simul_align: got %0d want 0", nmis); end
    endtask

    task automatic test_glitch();
        int nev = 0;
        for (int g = 0; g < 4; g++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            btn_in[0] = 1'b1;
            @(negedge clk);
            btn_in[0] = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                total++;
                if (dut_vec !== exp_vec) begin bad++; $display("FAIL glitch cyc%0d: got %b want %b", i, dut_vec, exp_vec); end
                if (btn_level[0] || btn_press[0] || btn_release[0]) nev++;
            end
        end
        total++;
        if (nev != 0) begin bad++; $display("FAIL glitch_visible: got %0d want 0", nev); end
    endtask

    task automatic test_random();
        int left = 0;
        for (int c = 0; c < 600; c++) begin
            if (left == 0) begin
                btn_in = N'($urandom_range(0, 3));
                left = $urandom_range(1, 24);
            end
            left--;
            @(negedge clk);
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL random cyc%0d: got %b want %b", c, dut_vec, exp_vec); end
        end
        btn_in = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner between the board button pins and the cellular-automata control logic (run/step/speed/pattern-select). One shared sample-tick prescaler drives N_BTN independent channels. Each channel synchronises its input, filters it by consecutive-sample agreement, and emits a debounced level, single-cycle press/release pulses, and an optional auto-repeat pulse while held. Asynchronous active-high reset replaces the power-up initialisers used by earlier debounce logic.

## Interface
- N_BTN, 5, number of independent button channels (1..16)
- SAMPLE_DIV, 250000, clk cycles per sample tick (2.5 ms at 100 MHz); must be >= 2
- STABLE_SAMPLES, 4, consecutive agreeing samples required to change a debounced level (>= 1)
- REPEAT_DELAY, 200, ticks a press must be held before the first repeat pulse; 0 disables repeat
- REPEAT_PERIOD, 40, ticks between subsequent repeat pulses (>= 1)

- clk  in  1  system clock (100 MHz on board)
- rst  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- btn_in  in  N_BTN  raw button pins, active-high, asynchronous to clk
- btn_level  out  N_BTN  debounced level per channel
- btn_press  out  N_BTN  1-cycle pulse on debounced 0->1
- btn_release  out  N_BTN  1-cycle pulse on debounced 1->0
- btn_repeat  out  N_BTN  1-cycle auto-repeat pulse while held
- sample_tick  out  1  prescaler tick, exported for observation/reuse

## Operation
- Synchroniser: two flops per channel; sync value s[i] = btn_in[i] delayed 2 clk. Reset value 0.
- Prescaler: counter 0..SAMPLE_DIV-1, wraps to 0; sample_tick=1 exactly in cycles where counter == SAMPLE_DIV-1. Free-running, not gated by button activity. Width $clog2(SAMPLE_DIV).
- Filter (per channel, acts only on sample_tick cycles): if s[i] == btn_level[i], agree counter cleared to 0. Else agree counter +1; when the incremented value equals STABLE_SAMPLES, btn_level[i] toggles and counter clears. Counter width $clog2(STABLE_SAMPLES+1); never exceeds STABLE_SAMPLES-1 at rest. Any single agreeing sample restarts the count.
- Pulses: btn_press/btn_release registered, high for exactly the one cycle in which btn_level[i] first shows its new value.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT:
  - IDLE: on debounced press -> DELAY, hold counter = 0 (only if REPEAT_DELAY != 0; otherwise remain IDLE).
  - DELAY: each tick hold counter +1; when it reaches REPEAT_DELAY -> pulse btn_repeat, counter = 0, -> REPEAT.
  - REPEAT: each tick counter +1; when it reaches REPEAT_PERIOD -> pulse btn_repeat, counter = 0, stay.
  - Any state: debounced release -> IDLE, counter = 0, no repeat pulse that cycle.
  - Hold counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1); no wrap possible.
- Channels fully independent; simultaneous events on several channels all reported in the same cycle.

## Timing
- Reset (async assert, sync deassert handled upstream): all outputs 0, prescaler 0, all counters 0, all FSMs IDLE, synchronisers 0. rst mid-press: outputs drop to 0 immediately; a still-held button is re-reported as a fresh press after STABLE_SAMPLES ticks following deassert.
- Latency input->level: 2 clk sync, then the STABLE_SAMPLES-th consecutive tick sampling the new value; btn_level/btn_press change on the clk edge after that tick cycle (1 cycle after sample_tick high).
- Worst-case latency: 2 + STABLE_SAMPLES*SAMPLE_DIV + 1 clk.
- btn_repeat asserts 1 clk after the qualifying tick, same as press. First repeat REPEAT_DELAY ticks after btn_press tick; then every REPEAT_PERIOD ticks.
- Press and repeat never coincide on a channel; release and repeat never coincide.
- Glitch shorter than one tick interval between samples: invisible. Bouncing spanning samples: filtered unless STABLE_SAMPLES consecutive samples agree.

## Test plan
(Bench parameters: N_BTN=2, SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_PERIOD=2.)
- Reset: assert rst with btn_in=2'b11 mid-run -> all outputs 0 asynchronously; sample_tick high every 4th clk after deassert; btn_level[1:0]=2'b11 with btn_press=2'b11 pulse after third tick.
- Clean press ch0: btn_in[0] 0->1 held -> btn_level[0] rises 1 clk after 3rd tick seeing s=1; btn_press[0] high exactly 1 clk; ch1 outputs unchanged.
- Bounce: btn_in[0] toggles such that samples read 1,1,0,1,1,1 -> single level rise after sixth tick, single btn_press pulse, no release.
- Repeat: hold ch1 for 20 ticks -> btn_repeat[1] pulses at ticks 5, 7, 9... after press tick; release -> btn_release[1] pulse, no further repeat, FSM IDLE.
- Simultaneous: both channels pressed same cycle, released 10 ticks later -> btn_press=2'b11 same cycle, btn_release=2'b11 same cycle, repeat pulses on both aligned.
- Short glitch: 1-clk high pulse on btn_in[0] between ticks -> no level change, no pulses.
